ibex_rf_wb_arbiter: RTL and testbench

Shares the register file's single write port between the EX writeback (ALU/MUL/CSR, zero-latency) and the LSU load-response writeback. Buffers LSU responses in a small FIFO and arbitrates the two sources with bounded EX starvation. Keeps a per-register pending-load scoreboard, so that ID detects RAW hazards and EX writes stay ordered behind outstanding loads (WAW). Sits between the EX/LSU stages and ibex_register_file_ff.

---
 rtl/ibex_rf_wb_pkg.sv | 31 +++
 rtl/ibex_rf_wb_fifo.sv | 61 ++++++
 rtl/ibex_rf_wb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ibex_rf_wb_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package ibex_rf_wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned WB_DATA_W  = 32;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0]  wdata;
    } wb_req_t;

    // Source that owns the write port in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_EX   = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

    // Number of architectural registers for the selected ISA variant.
    function automatic int unsigned num_words(input bit rv32e);
        return rv32e ? 32'd16 : 32'd32;
    endfunction

    // x0 and registers beyond the architectural set are never tracked.
    function automatic logic reg_tracked(input logic [REG_ADDR_W-1:0] addr, input bit rv32e);
        return (addr != '0) && (32'(addr) < num_words(rv32e));
    endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Synchronous FIFO buffering LSU load responses; a pushed entry becomes
// visible at the head on the following cycle.
module ibex_rf_wb_fifo
    import ibex_rf_wb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned     CntW    = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    wb_req_t         mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FullCnt);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= (wptr == LastPtr) ? '0 : wptr + PtrW'(1);
            end
            if (do_pop) begin
                rptr <= (rptr == LastPtr) ? '0 : rptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Shares the register-file write port between EX writeback and buffered
// LSU load responses, with bounded EX starvation and a per-register
// pending-load scoreboard for RAW/WAW hazards.
// Optional macro IBEX_RF_WB_FORWARD_EN: forward the committing load data
// to ID in the cycle its last pending load retires.
module ibex_rf_wb_arbiter
    import ibex_rf_wb_pkg::*;
#(
    parameter bit          RV32E          = 1'b0,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned LsuFifoDepth   = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StallMax       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_ready_o,
    input  logic                 issue_load_i,
    input  logic [4:0]           issue_load_rd_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    output logic                 fwd_a_o,
    output logic                 fwd_b_o,
    output logic [DataWidth-1:0] fwd_wdata_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o
);

    localparam int unsigned        CntW      = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0]    CntMax    = CntW'(MaxOutstanding);
    localparam int unsigned        StarveW   = (StallMax > 0) ? $clog2(StallMax + 1) : 1;
    localparam logic [StarveW-1:0] StarveMax = StarveW'(StallMax);

    wb_req_t             lsu_req;
    wb_req_t             fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    wb_src_e             src;
    logic                ex_ok;
    logic [StarveW-1:0]  starve_q;
    logic [StarveW-1:0]  starve_d;
    logic [CntW-1:0]     sb_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                pend_a;
    logic                pend_b;

    assign lsu_req.waddr = lsu_waddr_i;
    assign lsu_req.wdata = WB_DATA_W'(lsu_wdata_i);
    assign fifo_push     = lsu_valid_i && !fifo_full;
    assign lsu_ready_o   = !fifo_full;

    ibex_rf_wb_fifo #(
        .Depth (LsuFifoDepth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (fifo_push),
        .push_data (lsu_req),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // EX may only write once no older load to the same register is pending.
    assign ex_ok = ex_valid_i &&
                   !(reg_tracked(ex_waddr_i, RV32E) && (sb_cnt[ex_waddr_i] != '0));

    // Grant selection and write-port drive.
    always_comb begin
        src        = WB_NONE;
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        ex_ready_o = 1'b0;
        fifo_pop   = 1'b0;
        if (ex_ok && (starve_q == StarveMax)) begin
            src = WB_EX;
        end else if (!fifo_empty) begin
            src = WB_LSU;
        end else if (ex_ok) begin
            src = WB_EX;
        end
        case (src)
            WB_EX: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = ex_waddr_i;
                rf_wdata_o = ex_wdata_i;
                ex_ready_o = 1'b1;
            end
            WB_LSU: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = fifo_head.waddr;
                rf_wdata_o = DataWidth'(fifo_head.wdata);
                fifo_pop   = 1'b1;
            end
            default: ;
        endcase
    end

    // Count consecutive cycles an eligible EX request loses to the FIFO.
    always_comb begin
        starve_d = starve_q;
        if (!ex_valid_i || (src == WB_EX)) begin
            starve_d = '0;
        end else if (ex_ok && (src == WB_LSU) && (starve_q != StarveMax)) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    // Starve counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // One-hot issue and retire strobes per register.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_load_i && reg_tracked(issue_load_rd_i, RV32E)) begin
            inc_vec[issue_load_rd_i] = 1'b1;
        end
        if (fifo_pop && reg_tracked(fifo_head.waddr, RV32E)) begin
            dec_vec[fifo_head.waddr] = 1'b1;
        end
    end

    // Pending-load scoreboard; saturates at both ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                sb_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                if (inc_vec[r] && !dec_vec[r] && (sb_cnt[r] != CntMax)) begin
                    sb_cnt[r] <= sb_cnt[r] + CntW'(1);
                end else if (dec_vec[r] && !inc_vec[r] && (sb_cnt[r] != '0)) begin
                    sb_cnt[r] <= sb_cnt[r] - CntW'(1);
                end
            end
        end
    end

    assign pend_a = reg_tracked(raddr_a_i, RV32E) && (sb_cnt[raddr_a_i] != '0);
    assign pend_b = reg_tracked(raddr_b_i, RV32E) && (sb_cnt[raddr_b_i] != '0);

`ifdef IBEX_RF_WB_FORWARD_EN
    logic [NUM_REGS-1:0] clear_vec;

    // Registers whose last pending load retires this cycle.
    always_comb begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            clear_vec[r] = dec_vec[r] && !inc_vec[r] && (sb_cnt[r] == CntW'(1));
        end
    end

    assign fwd_a_o     = pend_a && clear_vec[raddr_a_i];
    assign fwd_b_o     = pend_b && clear_vec[raddr_b_i];
    assign hazard_a_o  = pend_a && !clear_vec[raddr_a_i];
    assign hazard_b_o  = pend_b && !clear_vec[raddr_b_i];
    assign fwd_wdata_o = rf_wdata_o;
`else
    assign fwd_a_o     = 1'b0;
    assign fwd_b_o     = 1'b0;
    assign hazard_a_o  = pend_a;
    assign hazard_b_o  = pend_b;
    assign fwd_wdata_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Self-checking bench for ibex_rf_wb_arbiter: directed scenarios plus
// randomized traffic compared every cycle against a queue/array model.
module tb_ibex_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int MAXO  = 2;
    localparam int STALL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic        issue_load;
    logic [4:0]  issue_rd;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic        hazard_a;
    logic        hazard_b;
    logic        fwd_a;
    logic        fwd_b;
    logic [31:0] fwd_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    ibex_rf_wb_arbiter #(
        .RV32E          (1'b0),
        .DataWidth      (32),
        .LsuFifoDepth   (DEPTH),
        .MaxOutstanding (MAXO),
        .StallMax       (STALL)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ex_valid_i      (ex_valid),
        .ex_waddr_i      (ex_waddr),
        .ex_wdata_i      (ex_wdata),
        .ex_ready_o      (ex_ready),
        .lsu_valid_i     (lsu_valid),
        .lsu_waddr_i     (lsu_waddr),
        .lsu_wdata_i     (lsu_wdata),
        .lsu_ready_o     (lsu_ready),
        .issue_load_i    (issue_load),
        .issue_load_rd_i (issue_rd),
        .raddr_a_i       (raddr_a),
        .raddr_b_i       (raddr_b),
        .hazard_a_o      (hazard_a),
        .hazard_b_o      (hazard_b),
        .fwd_a_o         (fwd_a),
        .fwd_b_o         (fwd_b),
        .fwd_wdata_o     (fwd_wdata),
        .rf_we_o         (rf_we),
        .rf_waddr_o      (rf_waddr),
        .rf_wdata_o      (rf_wdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: buffered responses {addr,data}, pending counts, starve count.
    logic [36:0] mq[$];
    int          mcnt[32];
    int          mstarve;
    logic [4:0]  pend[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend.delete();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        mstarve = 0;
    endtask

    task automatic idle();
        ex_valid = 0; ex_waddr = 0; ex_wdata = 0;
        lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
        issue_load = 0; issue_rd = 0;
        raddr_a = 0; raddr_b = 0;
    endtask

    // 0: no write, 1: EX, 2: buffered load response.
    function automatic int winner();
        bit ex_ok;
        ex_ok = ex_valid && (mcnt[ex_waddr] == 0);
        if (mstarve == STALL && ex_ok) return 1;
        if (mq.size() != 0) return 2;
        if (ex_ok) return 1;
        return 0;
    endfunction

    // Last pending load of r retires this cycle through the write port.
    function automatic bit retires(input logic [4:0] r, input int w);
        if (w != 2 || r == 0) return 0;
        if (mq[0][36:32] != r) return 0;
        if (issue_load && issue_rd == r) return 0;
        return mcnt[r] == 1;
    endfunction

    task automatic compare(input int w);
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ha, hb, fa, fb;
        wa = (w == 1) ? ex_waddr : (w == 2) ? mq[0][36:32] : 5'd0;
        wd = (w == 1) ? ex_wdata : (w == 2) ? mq[0][31:0] : 32'd0;
        ha = (raddr_a != 0) && (mcnt[raddr_a] != 0);
        hb = (raddr_b != 0) && (mcnt[raddr_b] != 0);
        fa = ha && retires(raddr_a, w);
        fb = hb && retires(raddr_b, w);
        chk("ex_ready", 32'(ex_ready), 32'(w == 1));
        chk("lsu_ready", 32'(lsu_ready), 32'(mq.size() < DEPTH));
        chk("rf_we", 32'(rf_we), 32'(w != 0));
        if (w != 0) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(wa));
            chk("rf_wdata", rf_wdata, wd);
        end
`ifdef IBEX_RF_WB_FORWARD_EN
        chk("hazard_a", 32'(hazard_a), 32'(ha && !fa));
        chk("hazard_b", 32'(hazard_b), 32'(hb && !fb));
        chk("fwd_a", 32'(fwd_a), 32'(fa));
        chk("fwd_b", 32'(fwd_b), 32'(fb));
        if (w != 0) chk("fwd_wdata", fwd_wdata, wd);
`else
        chk("hazard_a", 32'(hazard_a), 32'(ha));
        chk("hazard_b", 32'(hazard_b), 32'(hb));
        chk("fwd_a", 32'(fwd_a), 32'(fa && 1'b0));
        chk("fwd_b", 32'(fwd_b), 32'(fb && 1'b0));
        chk("fwd_wdata", fwd_wdata, 32'd0);
`endif
    endtask

    task automatic model_update(input int w);
        bit          ex_ok, push, pop;
        logic [4:0]  pr;
        logic [36:0] h;
        ex_ok = ex_valid && (mcnt[ex_waddr] == 0);
        push  = lsu_valid && (mq.size() < DEPTH);
        pop   = (w == 2);
        pr    = 0;
        if (pop) begin
            h  = mq.pop_front();
            pr = h[36:32];
        end
        if (push) mq.push_back({lsu_waddr, lsu_wdata});
        if (issue_load && issue_rd != 0 && !(pop && pr == issue_rd) && mcnt[issue_rd] < MAXO)
            mcnt[issue_rd]++;
        if (pop && pr != 0 && !(issue_load && issue_rd == pr) && mcnt[pr] > 0)
            mcnt[pr]--;
        if (!ex_valid || w == 1) mstarve = 0;
        else if (ex_ok && w == 2 && mstarve < STALL) mstarve++;
    endtask

    // Called with inputs settled; checks, then advances one clock.
    task automatic tick();
        int w;
        w = winner();
        compare(w);
        @(posedge clk);
        model_update(w);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_ex_ready", 32'(ex_ready), 32'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // EX alone every cycle.
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1; ex_waddr = 5; ex_wdata = 32'hA;
            #1;
            chk("t1_we", 32'(rf_we), 32'd1);
            chk("t1_waddr", 32'(rf_waddr), 32'd5);
            chk("t1_wdata", rf_wdata, 32'hA);
            chk("t1_ready", 32'(ex_ready), 32'd1);
            tick();
        end

        // Load x7: hazard window and commit.
        idle(); issue_load = 1; issue_rd = 7; raddr_a = 7;
        #1; chk("t2_haz_issue", 32'(hazard_a), 32'd0); tick();
        issue_load = 0;
        #1; chk("t2_haz_pend", 32'(hazard_a), 32'd1); tick();
        lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 32'h1234;
        #1; chk("t2_haz_resp", 32'(hazard_a), 32'd1); chk("t2_no_we", 32'(rf_we), 32'd0); tick();
        lsu_valid = 0;
        #1;
        chk("t2_we", 32'(rf_we), 32'd1);
        chk("t2_waddr", 32'(rf_waddr), 32'd7);
        chk("t2_wdata", rf_wdata, 32'h1234);
`ifdef IBEX_RF_WB_FORWARD_EN
        chk("t2_haz_commit", 32'(hazard_a), 32'd0);
        chk("t2_fwd_commit", 32'(fwd_a), 32'd1);
`else
        chk("t2_haz_commit", 32'(hazard_a), 32'd1);
        chk("t2_fwd_commit", 32'(fwd_a), 32'd0);
`endif
        tick();
        #1; chk("t2_haz_done", 32'(hazard_a), 32'd0); tick();

        // Bounded starvation of EX x3 behind a busy FIFO.
        idle(); lsu_valid = 1; lsu_waddr = 10; lsu_wdata = 32'h100;
        #1; tick();
        for (int i = 0; i < 5; i++) begin
            ex_valid = 1; ex_waddr = 3; ex_wdata = 32'h33;
            lsu_valid = 1; lsu_waddr = 5'(11 + i); lsu_wdata = 32'(i);
            #1;
            chk("t3_ex_ready", 32'(ex_ready), 32'(i == 4));
            tick();
        end
        idle();
        repeat (4) begin #1; tick(); end

        // WAW: EX x9 waits for the pending load to x9.
        idle(); issue_load = 1; issue_rd = 9;
        #1; tick();
        issue_load = 0; ex_valid = 1; ex_waddr = 9; ex_wdata = 32'h99;
        #1; chk("t4_blocked0", 32'(ex_ready), 32'd0); tick();
        lsu_valid = 1; lsu_waddr = 9; lsu_wdata = 32'h9999;
        #1; chk("t4_blocked1", 32'(ex_ready), 32'd0); tick();
        lsu_valid = 0;
        #1;
        chk("t4_commit_ready", 32'(ex_ready), 32'd0);
        chk("t4_commit_waddr", 32'(rf_waddr), 32'd9);
        chk("t4_commit_wdata", rf_wdata, 32'h9999);
        tick();
        #1;
        chk("t4_granted", 32'(ex_ready), 32'd1);
        chk("t4_wdata", rf_wdata, 32'h99);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bit do_issue, do_resp;
            logic [4:0] rd;
            idle();
            rd       = 5'($urandom_range(7));
            do_issue = ($urandom_range(99) < 30) && (mcnt[rd] < MAXO) && (pend.size() < 4);
            do_resp  = ($urandom_range(99) < 45) && (pend.size() != 0) && (mq.size() < DEPTH);
            issue_load = do_issue; issue_rd = do_issue ? rd : 5'd0;
            if (do_resp) begin
                lsu_valid = 1; lsu_waddr = pend[0]; lsu_wdata = $urandom;
            end
            ex_valid = ($urandom_range(99) < 60);
            ex_waddr = 5'($urandom_range(7));
            ex_wdata = $urandom;
            raddr_a  = 5'($urandom_range(7));
            raddr_b  = 5'($urandom_range(7));
            #1;
            tick();
            if (do_resp) void'(pend.pop_front());
            if (do_issue) pend.push_back(rd);
        end

        // Reset with buffered data and pending loads.
        idle(); issue_load = 1; issue_rd = 12;
        #1; tick();
        issue_rd = 13;
        #1; tick();
        issue_load = 0; ex_valid = 1; ex_waddr = 3; lsu_valid = 1; lsu_waddr = 12; lsu_wdata = 32'h5;
        #1; tick();
        idle(); raddr_a = 13; raddr_b = 12;
        rst_n = 0;
        #1;
        model_reset();
        chk("t6_we", 32'(rf_we), 32'd0);
        chk("t6_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("t6_haz_a", 32'(hazard_a), 32'd0);
        chk("t6_haz_b", 32'(hazard_b), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        repeat (3) begin
            #1;
            chk("t6_haz_after", 32'(hazard_a | hazard_b), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
